serial_in_parallel_out_receiver: RTL and testbench
==================================================

Name: serial_in_parallel_out_receiver

Overview:
Downstream companion to the 8-bit PISO shift register. It samples a framed serial bit stream, sent LSB first, and assembles it into a DATA_WIDTH-bit word. It then presents the word to a parallel consumer with a valid/ready handshake. A holding register double-buffers the output, so the next frame can be received while the current word waits; overruns and framing restarts are flagged.

Parameters:
DATA_WIDTH, 8, bits per frame; legal values 2..32
LSB_FIRST, 1, 1 = first received bit lands in bit 0; 0 = first received bit lands in bit DATA_WIDTH-1
CNT_W, $clog2(DATA_WIDTH), bit-counter width (derived localparam, not overridable)

Ports:
Clk_In  input  1  clock; all state updates on posedge (the upstream PISO launches on negedge, so this gives half-cycle setup)
Reset_In  input  1  reset, asynchronous, active-high
Frame_Start_In  input  1  high in the cycle the first bit of a frame is on Serial_Data_In
Serial_Data_In  input  1  serial data bit
Data_Ready_In  input  1  consumer accepts Parallel_Data_Out at a posedge when Data_Valid_Out=1
Error_Clear_In  input  1  synchronous clear of Overrun_Error_Out
Parallel_Data_Out  output  DATA_WIDTH  received word (holding register)
Data_Valid_Out  output  1  Parallel_Data_Out holds an unconsumed word
Overrun_Error_Out  output  1  sticky: a completed word was dropped
Frame_Error_Out  output  1  one-cycle pulse: a frame was restarted before completion
Bit_Count_Out  output  CNT_W  debug: bits received in the current frame
SIPO_Shift_Register  output  DATA_WIDTH  debug: assembly shift register

Behaviour:
- Reset (asynchronous): state=IDLE; shift register, bit count, Parallel_Data_Out all 0; Data_Valid_Out, Overrun_Error_Out, Frame_Error_Out all 0.
- States: IDLE, SHIFT. State encodings are localparams.
- Shift insertion:
  - LSB_FIRST=1: sr <= {Serial_Data_In, sr[DATA_WIDTH-1:1]}.
  - LSB_FIRST=0: sr <= {sr[DATA_WIDTH-2:0], Serial_Data_In}.
  - After DATA_WIDTH samples, the first bit is at bit 0 (or bit DATA_WIDTH-1 for LSB_FIRST=0).
- IDLE: Serial_Data_In is ignored unless Frame_Start_In=1. On Frame_Start_In=1: sample bit 0, count=1, go to SHIFT.
- SHIFT: sample one bit per posedge, count+1.
  - The sample that brings count to DATA_WIDTH completes the word. Count returns to 0 and state returns to IDLE.
  - The completed word, including the bit sampled at that edge, is the value for the holding-register transfer.
- Latency: frame starting at posedge k gives Data_Valid_Out=1 and valid data after posedge k+DATA_WIDTH-1.
- Back-to-back frames: Frame_Start_In in the cycle right after completion is legal; no gap cycle is needed.
- Restart: Frame_Start_In=1 while in SHIFT abandons the partial word. The current bit is taken as bit 0 of a new frame, count=1, and Frame_Error_Out pulses for one cycle. Frame_Start_In on the completing sample also counts as a restart; that word is discarded.
- Handshake:
  - Data_Valid_Out stays 1 and Parallel_Data_Out stays stable until a posedge with Data_Ready_In=1; valid then clears.
  - Data_Ready_In is ignored while valid=0.
- Word completes and (valid=0, or valid=1 with Ready=1) at the same edge: load the holding register and set valid=1. There are no bubbles.
- Word completes while valid=1 and Ready=0: the new word is dropped, the holding register is unchanged, and Overrun_Error_Out is set.
- Overrun_Error_Out stays set until Error_Clear_In=1 or reset. If clear and a new overrun occur at the same edge, set wins.
- Reset mid-frame: the partial word is lost, and a subsequent frame is received cleanly from Frame_Start_In.
- Counter never exceeds DATA_WIDTH-1 in SHIFT; no wrap-around path exists.

Decomposition:
- Shared header piso_sipo_defs.vh holds the default width (8) and the IDLE/SHIFT state encodings. These are shared with the PISO and future serial-link blocks.
- Single module; no sub-module is needed. The holding register and handshake are simple enough to stay inline.

Test Plan:
- Reset, Frame_Start_In at edge 1 with bits 1,0,1,0,0,1,0,1 -> Parallel_Data_Out=8'hA5, Data_Valid_Out=1 after edge 8; Bit_Count_Out goes 1..7 then 0.
- Data_Ready_In=1, back-to-back frames 8'h3C then 8'hC3 with no gap -> valid high after edges 8 and 16, each word shown for one cycle, no overrun.
- Data_Ready_In=0, frames 8'h11 then 8'h22 -> output holds 8'h11, Overrun_Error_Out=1. Ready=1 then accepts 8'h11 and valid drops. Error_Clear_In clears the flag.
- Frame_Start_In re-asserted at 4th bit of a frame, followed by 8 bits of 8'h5A -> Frame_Error_Out pulses once, output=8'h5A, partial word never appears.
- Reset_In asserted asynchronously mid-frame (between edges 5 and 6), then released, then full frame 8'hFF -> all outputs 0 during reset; 8'hFF received correctly.
- PISO integration: PISO loads 8'h96 on negedge, shifts with Frame_Start_In aligned to bit 0 -> Parallel_Data_Out=8'h96; repeat with LSB_FIRST=0 -> 8'h69.

Source files
------------

// File: rtl/serial_in_parallel_out_receiver_pkg.sv
// Shared definitions for the serial-link receive path.
// Holds the default frame width and the state encodings.
package serial_in_parallel_out_receiver_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Encodings are shared with the PISO and later serial-link blocks.
  localparam logic STATE_IDLE  = 1'b0;
  localparam logic STATE_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = STATE_IDLE,
    SHIFT = STATE_SHIFT
  } state_t;

endpackage

// File: rtl/serial_in_parallel_out_receiver_if.sv
// Serial-in / parallel-out bus: the framed serial input, the valid/ready word
// output, the error flags and the debug taps.
interface serial_in_parallel_out_receiver_if
  import serial_in_parallel_out_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  logic                  Frame_Start_In;
  logic                  Serial_Data_In;
  logic                  Data_Ready_In;
  logic                  Error_Clear_In;
  logic [DATA_WIDTH-1:0] Parallel_Data_Out;
  logic                  Data_Valid_Out;
  logic                  Overrun_Error_Out;
  logic                  Frame_Error_Out;
  logic [CNT_W-1:0]      Bit_Count_Out;
  logic [DATA_WIDTH-1:0] SIPO_Shift_Register;

  // Sender and consumer side.
  modport master (
    output Frame_Start_In, Serial_Data_In, Data_Ready_In, Error_Clear_In,
    input  Parallel_Data_Out, Data_Valid_Out, Overrun_Error_Out,
           Frame_Error_Out, Bit_Count_Out, SIPO_Shift_Register
  );

  // Receiver side.
  modport slave (
    input  Frame_Start_In, Serial_Data_In, Data_Ready_In, Error_Clear_In,
    output Parallel_Data_Out, Data_Valid_Out, Overrun_Error_Out,
           Frame_Error_Out, Bit_Count_Out, SIPO_Shift_Register
  );

endinterface

// File: rtl/serial_in_parallel_out_receiver.sv
// Framed serial receiver: shifts a DATA_WIDTH-bit frame in, then hands it to a
// valid/ready consumer via a holding register. Overrun and restart are flagged.
module serial_in_parallel_out_receiver
  import serial_in_parallel_out_receiver_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter bit          LSB_FIRST  = 1'b1
) (
  input  logic                             Clk_In,
  input  logic                             Reset_In,
  serial_in_parallel_out_receiver_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

  state_t                state;
  logic [DATA_WIDTH-1:0] sr;
  logic [DATA_WIDTH-1:0] sr_next_c;
  logic [DATA_WIDTH-1:0] hold;
  logic [CNT_W-1:0]      count;
  logic                  valid;
  logic                  overrun;
  logic                  frame_err;
  logic                  last_bit_c;
  logic                  accept_c;

  // Bit insertion order fixes where the first received bit ends up.
  if (LSB_FIRST) begin : g_lsb_first
    assign sr_next_c = {bus.Serial_Data_In, sr[DATA_WIDTH-1:1]};
  end else begin : g_msb_first
    assign sr_next_c = {sr[DATA_WIDTH-2:0], bus.Serial_Data_In};
  end

  assign last_bit_c = (count == CNT_W'(DATA_WIDTH - 1));
  assign accept_c   = valid & bus.Data_Ready_In;

  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state     <= IDLE;
      sr        <= '0;
      count     <= '0;
      hold      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (accept_c)           valid   <= 1'b0;
      if (bus.Error_Clear_In) overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.Frame_Start_In) begin
            sr    <= sr_next_c;
            count <= CNT_W'(1);
            state <= SHIFT;
          end
        end

        SHIFT: begin
          sr <= sr_next_c;
          if (bus.Frame_Start_In) begin
            // Restart: the current bit becomes bit 0 of a fresh frame.
            count     <= CNT_W'(1);
            frame_err <= 1'b1;
          end else if (last_bit_c) begin
            count <= '0;
            state <= IDLE;
            // Free or freeing this edge: load; otherwise the new word is lost.
            if (!valid || bus.Data_Ready_In) begin
              hold  <= sr_next_c;
              valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            count <= count + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Parallel_Data_Out   = hold;
  assign bus.Data_Valid_Out      = valid;
  assign bus.Overrun_Error_Out   = overrun;
  assign bus.Frame_Error_Out     = frame_err;
  assign bus.Bit_Count_Out       = count;
  assign bus.SIPO_Shift_Register = sr;

endmodule

// File: tb/tb_serial_in_parallel_out_receiver.sv
// Directed bench for the SIPO receiver; an LSB-first and an MSB-first instance
// share one stimulus stream.
module tb_serial_in_parallel_out_receiver;

  logic clk;
  logic rst;

  int tests_run    = 0;
  int tests_failed = 0;

  serial_in_parallel_out_receiver_if #(.DATA_WIDTH(8)) bus ();
  serial_in_parallel_out_receiver_if #(.DATA_WIDTH(8)) bus_m ();

  assign bus_m.Frame_Start_In = bus.Frame_Start_In;
  assign bus_m.Serial_Data_In = bus.Serial_Data_In;
  assign bus_m.Data_Ready_In  = bus.Data_Ready_In;
  assign bus_m.Error_Clear_In = bus.Error_Clear_In;

  serial_in_parallel_out_receiver #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) dut (
    .Clk_In   (clk),
    .Reset_In (rst),
    .bus      (bus)
  );

  serial_in_parallel_out_receiver #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) dut_m (
    .Clk_In   (clk),
    .Reset_In (rst),
    .bus      (bus_m)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Launch on negedge like the upstream PISO, then sample just after posedge.
  task automatic drive_bit(input logic fs, input logic sd);
    @(negedge clk);
    bus.Frame_Start_In = fs;
    bus.Serial_Data_In = sd;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive_bit(i == 0, w[i]);
  endtask

  task automatic test_reset();
    rst                = 1'b1;
    bus.Frame_Start_In = 1'b0;
    bus.Serial_Data_In = 1'b0;
    bus.Data_Ready_In  = 1'b0;
    bus.Error_Clear_In = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (bus.Parallel_Data_Out !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", bus.Parallel_Data_Out); end
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.Data_Valid_Out); end
    tests_run++;
    if (bus.Overrun_Error_Out !== 1'b0 || bus.Frame_Error_Out !== 1'b0) begin tests_failed++; $display("FAIL reset_flags: got ovr=%b ferr=%b expected 0 0", bus.Overrun_Error_Out, bus.Frame_Error_Out); end
    tests_run++;
    if (bus.Bit_Count_Out !== 3'd0 || bus.SIPO_Shift_Register !== 8'h00) begin tests_failed++; $display("FAIL reset_debug: got cnt=%0d sr=%h expected 0 00", bus.Bit_Count_Out, bus.SIPO_Shift_Register); end
    @(negedge clk);
    rst = 1'b0;
    // Serial data without a frame start must be ignored.
    drive_bit(1'b0, 1'b1);
    tests_run++;
    if (bus.Bit_Count_Out !== 3'd0 || bus.SIPO_Shift_Register !== 8'h00) begin tests_failed++; $display("FAIL idle_ignore: got cnt=%0d sr=%h expected 0 00", bus.Bit_Count_Out, bus.SIPO_Shift_Register); end
  endtask

  task automatic test_basic_frame();
    logic [7:0] w;
    logic [2:0] exp_cnt;
    w = 8'hA5;
    bus.Data_Ready_In = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_bit(i == 0, w[i]);
      exp_cnt = (i == 7) ? 3'd0 : 3'(i + 1);
      tests_run++;
      if (bus.Bit_Count_Out !== exp_cnt) begin tests_failed++; $display("FAIL basic_count[%0d]: got %0d expected %0d", i, bus.Bit_Count_Out, exp_cnt); end
      tests_run++;
      if (bus.Data_Valid_Out !== (i == 7)) begin tests_failed++; $display("FAIL basic_valid[%0d]: got %b expected %b", i, bus.Data_Valid_Out, (i == 7)); end
    end
    tests_run++;
    if (bus.Parallel_Data_Out !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %h expected a5", bus.Parallel_Data_Out); end
    // Held while ready is low.
    drive_bit(1'b0, 1'b0);
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b1 || bus.Parallel_Data_Out !== 8'hA5) begin tests_failed++; $display("FAIL basic_hold: got v=%b d=%h expected 1 a5", bus.Data_Valid_Out, bus.Parallel_Data_Out); end
    bus.Data_Ready_In = 1'b1;
    drive_bit(1'b0, 1'b0);
    bus.Data_Ready_In = 1'b0;
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b0) begin tests_failed++; $display("FAIL basic_accept: got %b expected 0", bus.Data_Valid_Out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [2];
    words[0] = 8'h3C;
    words[1] = 8'hC3;
    bus.Data_Ready_In = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) begin
        drive_bit(i == 0, words[f][i]);
        if (f == 1 && i == 0) begin
          tests_run++;
          if (bus.Data_Valid_Out !== 1'b0) begin tests_failed++; $display("FAIL b2b_one_cycle: got %b expected 0", bus.Data_Valid_Out); end
        end
        if (i == 7) begin
          tests_run++;
          if (bus.Data_Valid_Out !== 1'b1 || bus.Parallel_Data_Out !== words[f]) begin tests_failed++; $display("FAIL b2b_word%0d: got v=%b d=%h expected 1 %h", f, bus.Data_Valid_Out, bus.Parallel_Data_Out, words[f]); end
        end
      end
    end
    drive_bit(1'b0, 1'b0);
    bus.Data_Ready_In = 1'b0;
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b0 || bus.Overrun_Error_Out !== 1'b0) begin tests_failed++; $display("FAIL b2b_end: got v=%b ovr=%b expected 0 0", bus.Data_Valid_Out, bus.Overrun_Error_Out); end
  endtask

  task automatic test_overrun();
    logic [7:0] w;
    bus.Data_Ready_In = 1'b0;
    send_word(8'h11);
    send_word(8'h22);
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b1 || bus.Parallel_Data_Out !== 8'h11 || bus.Overrun_Error_Out !== 1'b1) begin tests_failed++; $display("FAIL ovr_drop: got v=%b d=%h ovr=%b expected 1 11 1", bus.Data_Valid_Out, bus.Parallel_Data_Out, bus.Overrun_Error_Out); end
    bus.Data_Ready_In = 1'b1;
    drive_bit(1'b0, 1'b0);
    bus.Data_Ready_In = 1'b0;
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b0 || bus.Parallel_Data_Out !== 8'h11 || bus.Overrun_Error_Out !== 1'b1) begin tests_failed++; $display("FAIL ovr_accept: got v=%b d=%h ovr=%b expected 0 11 1", bus.Data_Valid_Out, bus.Parallel_Data_Out, bus.Overrun_Error_Out); end
    bus.Error_Clear_In = 1'b1;
    drive_bit(1'b0, 1'b0);
    bus.Error_Clear_In = 1'b0;
    tests_run++;
    if (bus.Overrun_Error_Out !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear: got %b expected 0", bus.Overrun_Error_Out); end
    // Clear coinciding with a fresh overrun: the set must win.
    send_word(8'h33);
    w = 8'h44;
    for (int i = 0; i < 8; i++) begin
      bus.Error_Clear_In = (i == 7);
      drive_bit(i == 0, w[i]);
    end
    bus.Error_Clear_In = 1'b0;
    tests_run++;
    if (bus.Overrun_Error_Out !== 1'b1 || bus.Parallel_Data_Out !== 8'h33) begin tests_failed++; $display("FAIL ovr_set_wins: got ovr=%b d=%h expected 1 33", bus.Overrun_Error_Out, bus.Parallel_Data_Out); end
    bus.Data_Ready_In  = 1'b1;
    bus.Error_Clear_In = 1'b1;
    drive_bit(1'b0, 1'b0);
    bus.Data_Ready_In  = 1'b0;
    bus.Error_Clear_In = 1'b0;
    tests_run++;
    if (bus.Overrun_Error_Out !== 1'b0 || bus.Data_Valid_Out !== 1'b0) begin tests_failed++; $display("FAIL ovr_cleanup: got ovr=%b v=%b expected 0 0", bus.Overrun_Error_Out, bus.Data_Valid_Out); end
  endtask

  task automatic test_restart();
    logic [7:0] w;
    bus.Data_Ready_In = 1'b0;
    drive_bit(1'b1, 1'b1);
    drive_bit(1'b0, 1'b1);
    drive_bit(1'b0, 1'b1);
    w = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      drive_bit(i == 0, w[i]);
      if (i == 0) begin
        tests_run++;
        if (bus.Frame_Error_Out !== 1'b1 || bus.Bit_Count_Out !== 3'd1) begin tests_failed++; $display("FAIL restart_pulse: got ferr=%b cnt=%0d expected 1 1", bus.Frame_Error_Out, bus.Bit_Count_Out); end
      end else begin
        tests_run++;
        if (bus.Frame_Error_Out !== 1'b0) begin tests_failed++; $display("FAIL restart_single[%0d]: got %b expected 0", i, bus.Frame_Error_Out); end
      end
      if (i < 7) begin
        tests_run++;
        if (bus.Data_Valid_Out !== 1'b0) begin tests_failed++; $display("FAIL restart_no_partial[%0d]: got %b expected 0", i, bus.Data_Valid_Out); end
      end
    end
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b1 || bus.Parallel_Data_Out !== 8'h5A) begin tests_failed++; $display("FAIL restart_word: got v=%b d=%h expected 1 5a", bus.Data_Valid_Out, bus.Parallel_Data_Out); end
    bus.Data_Ready_In = 1'b1;
    drive_bit(1'b0, 1'b0);
    bus.Data_Ready_In = 1'b0;
    // Restart landing on the completing sample discards that word.
    for (int i = 0; i < 7; i++) drive_bit(i == 0, 1'b1);
    w = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      drive_bit(i == 0, w[i]);
      if (i == 0) begin
        tests_run++;
        if (bus.Frame_Error_Out !== 1'b1 || bus.Data_Valid_Out !== 1'b0 || bus.Bit_Count_Out !== 3'd1) begin tests_failed++; $display("FAIL restart_last: got ferr=%b v=%b cnt=%0d expected 1 0 1", bus.Frame_Error_Out, bus.Data_Valid_Out, bus.Bit_Count_Out); end
      end
    end
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b1 || bus.Parallel_Data_Out !== 8'h0F) begin tests_failed++; $display("FAIL restart_last_word: got v=%b d=%h expected 1 0f", bus.Data_Valid_Out, bus.Parallel_Data_Out); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] w;
    w = 8'hC3;
    for (int i = 0; i < 5; i++) drive_bit(i == 0, w[i]);
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.Bit_Count_Out !== 3'd0 || bus.SIPO_Shift_Register !== 8'h00) begin tests_failed++; $display("FAIL midrst_debug: got cnt=%0d sr=%h expected 0 00", bus.Bit_Count_Out, bus.SIPO_Shift_Register); end
    tests_run++;
    if (bus.Parallel_Data_Out !== 8'h00 || bus.Data_Valid_Out !== 1'b0) begin tests_failed++; $display("FAIL midrst_out: got d=%h v=%b expected 00 0", bus.Parallel_Data_Out, bus.Data_Valid_Out); end
    tests_run++;
    if (bus.Overrun_Error_Out !== 1'b0 || bus.Frame_Error_Out !== 1'b0) begin tests_failed++; $display("FAIL midrst_flags: got ovr=%b ferr=%b expected 0 0", bus.Overrun_Error_Out, bus.Frame_Error_Out); end
    @(negedge clk);
    rst = 1'b0;
    send_word(8'hFF);
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b1 || bus.Parallel_Data_Out !== 8'hFF || bus.Frame_Error_Out !== 1'b0) begin tests_failed++; $display("FAIL midrst_word: got v=%b d=%h ferr=%b expected 1 ff 0", bus.Data_Valid_Out, bus.Parallel_Data_Out, bus.Frame_Error_Out); end
  endtask

  task automatic test_piso();
    logic [7:0] piso;
    bus.Data_Ready_In = 1'b1;
    drive_bit(1'b0, 1'b0);
    bus.Data_Ready_In = 1'b0;
    // Upstream PISO model: loads on negedge, shifts LSB out each negedge.
    piso = 8'h96;
    for (int i = 0; i < 8; i++) begin
      drive_bit(i == 0, piso[0]);
      piso = piso >> 1;
    end
    tests_run++;
    if (bus.Data_Valid_Out !== 1'b1 || bus.Parallel_Data_Out !== 8'h96) begin tests_failed++; $display("FAIL piso_lsb: got v=%b d=%h expected 1 96", bus.Data_Valid_Out, bus.Parallel_Data_Out); end
    tests_run++;
    if (bus_m.Data_Valid_Out !== 1'b1 || bus_m.Parallel_Data_Out !== 8'h69) begin tests_failed++; $display("FAIL piso_msb: got v=%b d=%h expected 1 69", bus_m.Data_Valid_Out, bus_m.Parallel_Data_Out); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_overrun();
    test_restart();
    test_reset_mid_frame();
    test_piso();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
